mem_port_sched: RTL
===================

# mem_port_sched

Sequencer and arbiter for the single shared memory port of the multicycle RISC-V datapath. It accepts instruction-fetch reads from the fetch stage and data load/store requests from the execute stage. It serialises them onto one memory port with fixed read latency and returns data with a one-cycle valid pulse. The control unit sequences its states on the GNT/VALID handshakes instead of fixed cycle counts.

## Interface
- AW, 32, address width
- DW, 64, memory/data-port word width; fetch port uses the low 32 bits
- LAT, 2, memory read latency in cycles (1..7)

- CLK  in  1  clock; all state on rising edge
- RESET  in  1  reset, asynchronous, active-high
- IF_REQ  in  1  fetch read request; held until IF_GNT
- IF_ADDR  in  AW  fetch address; held with IF_REQ
- IF_GNT  out  1  one-cycle pulse: fetch request accepted
- IF_VALID  out  1  one-cycle pulse: IF_RDATA valid
- IF_RDATA  out  32  fetched instruction; holds until next fetch completes
- DM_REQ  in  1  data request; held until DM_GNT
- DM_WE  in  1  1 = store, 0 = load
- DM_ADDR  in  AW  data address
- DM_WDATA  in  DW  store data
- DM_GNT  out  1  one-cycle pulse: data request accepted
- DM_VALID  out  1  one-cycle pulse: load data valid / store complete
- DM_RDATA  out  DW  load data; holds until next load completes
- MEM_ADDR  out  AW  memory address
- MEM_WE  out  1  memory write strobe
- MEM_WDATA  out  DW  memory write data
- MEM_RDATA  in  DW  memory read data, valid LAT cycles after address presented
- BUSY  out  1  transaction in flight (state != IDLE)
- OWNER  out  1  0 = fetch, 1 = data; meaningful while BUSY

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: each rising edge samples IF_REQ/DM_REQ. If either is high, it picks a winner and latches addr/we/wdata and OWNER. It then moves to ACCESS. With no request it stays in IDLE.
- Arbitration when both requests are high: see Configuration. A single requester always wins.
- ACCESS (1 cycle): pulses GNT of the winner and drives MEM_ADDR from the latch. For a store, MEM_WE=1 and MEM_WDATA are driven this cycle only, then the FSM goes to DONE. For a load, the 3-bit wait counter is loaded with LAT-1. The FSM goes to WAIT, or to DONE if LAT=1.
- WAIT: MEM_ADDR is held and the counter decrements. The FSM leaves for DONE on the edge where the counter is 1. On that same edge, which is the LAT-th edge after ACCESS begins, MEM_RDATA is captured into IF_RDATA (low 32 bits) or DM_RDATA.
- For LAT=1, capture happens on the edge leaving ACCESS.
- DONE (1 cycle): pulses VALID of the owner, then returns to IDLE unconditionally.
- Once latched, a transaction always completes even if REQ drops. A REQ dropped before it is sampled in IDLE is simply not served.
- The requester must deassert REQ on the cycle after seeing GNT, or a second transaction is issued.
- MEM_ADDR holds its last value in IDLE. MEM_WE is 0 in every state except ACCESS for a store.

## Timing
- Reset values: state IDLE; IF_GNT, DM_GNT, IF_VALID, DM_VALID, MEM_WE, BUSY, OWNER = 0; IF_RDATA, DM_RDATA, MEM_ADDR, MEM_WDATA = 0; round-robin pointer = last-served DM.
- All outputs are registered or decoded from state only; there is no combinational REQ-to-GNT path.
- If REQ is sampled at edge 0, GNT is high in cycle 1.
- For a load, VALID is high in cycle LAT+1. For a store, VALID is high in cycle 2.
- Occupancy is LAT+2 cycles per load and 3 cycles per store, including the IDLE sample cycle.
- RESET asserted mid-transaction clears MEM_WE and all pulses immediately (asynchronously). The FSM returns to IDLE; the aborted transaction produces no VALID.

## Configuration
- MEM_PORT_SCHED_RR_EN defined: round-robin. When both requests are high in IDLE, the requester not served last wins. The pointer updates at every grant. After reset, fetch wins first.
- Not defined: fixed priority, data always beats fetch. There is no pointer register.

## Test plan
- LAT=2, IF_REQ only, IF_ADDR=0x0000_0010, MEM_RDATA=0x00A0_0093 -> IF_GNT in cycle 1, IF_VALID in cycle 3, IF_RDATA=0x00A0_0093, DM_VALID stays 0.
- DM store, DM_ADDR=0x40, DM_WDATA=0x1122334455667788 -> MEM_WE high exactly one cycle (cycle 1) with MEM_ADDR=0x40, DM_VALID in cycle 2.
- IF_REQ and DM_REQ both held from reset release, with RR_EN -> grants alternate IF, DM, IF, DM. Without RR_EN -> DM granted until DM_REQ is dropped, then IF.
- LAT=1 and LAT=7 loads -> DM_VALID in cycle 2 and cycle 8 respectively; DM_RDATA equals MEM_RDATA at capture and holds through a following store.
- RESET pulsed during WAIT of a load -> BUSY=0 and all pulses 0 immediately, no DM_VALID. The next IF_REQ is served normally with GNT one cycle after sampling.
- DM_REQ dropped in cycle 2 after its GNT -> the transaction still completes with DM_VALID, and no second grant is issued.

Source files
------------

// File: rtl/mem_port_sched.sv
// Shared memory-port sequencer: arbitrates fetch and data requests onto one fixed-latency port.
// Define MEM_PORT_SCHED_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_sched #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int LAT = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_VALID,
    output logic [31:0]   IF_RDATA,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    output logic          DM_GNT,
    output logic          DM_VALID,
    output logic [DW-1:0] DM_RDATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY,
    output logic          OWNER
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(LAT - 1);
    localparam bit         LAT_ONE   = (LAT == 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          capture_s;
    logic          win_dm_s;

`ifdef MEM_PORT_SCHED_RR_EN
    logic          last_dm_q, last_dm_d;

    // Winner select: on a tie the requester that was not served last takes the port.
    always_comb begin
        win_dm_s = DM_REQ && !(IF_REQ && last_dm_q);
    end

    // Pointer follows every grant made in IDLE.
    always_comb begin
        if ((state_q == S_IDLE) && (IF_REQ || DM_REQ)) begin
            last_dm_d = win_dm_s;
        end else begin
            last_dm_d = last_dm_q;
        end
    end

    // Round-robin pointer register; reset points at data so fetch wins the first tie.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_dm_q <= 1'b1;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    // Winner select: data has fixed priority over fetch.
    always_comb begin
        win_dm_s = DM_REQ;
    end
`endif

    // Next-state, transaction latch and read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        capture_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IF_REQ || DM_REQ) begin
                    owner_d = win_dm_s;
                    we_d    = win_dm_s && DM_WE;
                    addr_d  = win_dm_s ? DM_ADDR : IF_ADDR;
                    wdata_d = win_dm_s ? DM_WDATA : wdata_q;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                cnt_d = WAIT_INIT;
                if (we_q) begin
                    state_d = S_DONE;
                end else if (LAT_ONE) begin
                    capture_s = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    capture_s = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is captured on the edge that leaves the last latency cycle.
        if (capture_s) begin
            if (owner_q) begin
                dm_rdata_d = MEM_RDATA;
                if_rdata_d = if_rdata_q;
            end else begin
                dm_rdata_d = dm_rdata_q;
                if_rdata_d = MEM_RDATA[31:0];
            end
        end else begin
            dm_rdata_d = dm_rdata_q;
            if_rdata_d = if_rdata_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            cnt_q      <= 3'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Handshake pulses decode from flopped state only, so RESET clears them at once.
    assign IF_GNT    = (state_q == S_ACCESS) && !owner_q;
    assign DM_GNT    = (state_q == S_ACCESS) &&  owner_q;
    assign IF_VALID  = (state_q == S_DONE)   && !owner_q;
    assign DM_VALID  = (state_q == S_DONE)   &&  owner_q;
    assign MEM_WE    = (state_q == S_ACCESS) &&  we_q;
    assign BUSY      = (state_q != S_IDLE);
    assign OWNER     = owner_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign IF_RDATA  = if_rdata_q;
    assign DM_RDATA  = dm_rdata_q;

endmodule
